// File: rtl/frame_scheduler.sv
// frame_scheduler
//   Walks an object table once per frame and issues one fetch request per
//   facet to the vertex-fetch unit, limiting the number of triangles that are
//   issued but not yet retired. The frame completes once every issued
//   triangle has retired.
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   frame_start_in  one-cycle pulse that starts a frame
//   obj_idx_out     object-table index being looked up
//   obj_base_in     first facet address of object obj_idx_out (same cycle)
//   obj_count_in    facet count of object obj_idx_out (same cycle)
//   tri_valid_out   facet fetch request valid
//   tri_ready_in    fetch unit accepts the request
//   facet_addr_out  facet address of the request
//   obj_id_out      object index of the request
//   tri_retire_in   one-cycle pulse: one triangle finished downstream
//   busy_out        frame in progress (accept through the done cycle)
//   frame_done_out  one-cycle pulse when the frame has fully retired
//   overrun_out     sticky: frame_start_in seen while not idle
module frame_scheduler #(
  parameter int NUM_OBJECTS  = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_start_in,
  output logic [3:0]  obj_idx_out,
  input  logic [11:0] obj_base_in,
  input  logic [11:0] obj_count_in,
  output logic        tri_valid_out,
  input  logic        tri_ready_in,
  output logic [11:0] facet_addr_out,
  output logic [3:0]  obj_id_out,
  input  logic        tri_retire_in,
  output logic        busy_out,
  output logic        frame_done_out,
  output logic        overrun_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  localparam logic [3:0] LAST_OBJ = 4'(NUM_OBJECTS - 1);
  localparam logic [3:0] MAX_IF   = 4'(MAX_INFLIGHT);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_obj_idx;
  logic [11:0] r_ptr;
  logic [11:0] r_rem;
  logic [3:0]  r_inflight;
  logic        r_valid;
  logic        r_busy;
  logic        r_overrun;

  logic        w_xfer;
  logic        w_ret;
  logic [3:0]  w_inflight_nxt;
  logic        w_can_issue;
  logic        w_last_obj;
  logic        w_last_facet;
  logic        w_cnt_zero;
  logic        w_frame_done;

  assign w_xfer         = r_valid & tri_ready_in;
  // A retire with nothing in flight is dropped so the counter never wraps.
  assign w_ret          = tri_retire_in & (r_inflight != 4'd0);
  assign w_inflight_nxt = r_inflight + {3'd0, w_xfer} - {3'd0, w_ret};
  // Decide the next request against the post-edge inflight count so the
  // registered valid never exceeds the limit.
  assign w_can_issue    = (w_inflight_nxt < MAX_IF);
  assign w_last_obj     = (r_obj_idx == LAST_OBJ);
  assign w_last_facet   = (r_rem == 12'd1);
  assign w_cnt_zero     = (obj_count_in == 12'd0);

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE:  if (frame_start_in) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (!w_cnt_zero)     w_state_nxt = S_ISSUE;
        else if (w_last_obj) w_state_nxt = S_DRAIN;
      end
      S_ISSUE: if (w_xfer && w_last_facet) w_state_nxt = w_last_obj ? S_DRAIN : S_LOAD;
      S_DRAIN: if (r_inflight == 4'd0) w_state_nxt = S_DONE;
      S_DONE: begin
        w_frame_done = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_obj_idx  <= 4'd0;
      r_ptr      <= 12'd0;
      r_rem      <= 12'd0;
      r_inflight <= 4'd0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_inflight_nxt;
      if (frame_start_in && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (frame_start_in) begin
            r_obj_idx <= 4'd0;
            r_busy    <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_cnt_zero) begin
            if (!w_last_obj) r_obj_idx <= r_obj_idx + 4'd1;
          end else begin
            // First request is presented in the ISSUE entry cycle.
            r_ptr   <= obj_base_in;
            r_rem   <= obj_count_in;
            r_valid <= w_can_issue;
          end
        end
        S_ISSUE: begin
          if (w_xfer) begin
            r_ptr <= r_ptr + 12'd1;  // wraps modulo 4096
            r_rem <= r_rem - 12'd1;
            if (w_last_facet) begin
              r_valid <= 1'b0;
              if (!w_last_obj) r_obj_idx <= r_obj_idx + 4'd1;
            end else begin
              r_valid <= w_can_issue;
            end
          end else if (!r_valid) begin
            // Held-off request resumes as soon as a retire frees a slot;
            // a presented request is held until it transfers.
            r_valid <= w_can_issue;
          end
        end
        S_DONE:  r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign obj_idx_out    = r_obj_idx;
  assign tri_valid_out  = r_valid;
  assign facet_addr_out = r_ptr;
  assign obj_id_out     = r_obj_idx;
  assign busy_out       = r_busy;
  assign frame_done_out = w_frame_done;
  assign overrun_out    = r_overrun;

endmodule
